branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised branch prediction and resolution unit for the 5-stage pipeline.
//  IF side: direct-mapped BTB with saturating counters gives a predicted next PC.
//  EX side: resolves branches/JAL/JALR from comparator flags, drives BrUn/ASel,
//  flags mispredicts with a redirect PC, trains the BTB and keeps perf counters.
// PARAMETERS
//  XLEN        32  address/data width
//  BTB_ENTRIES 16  BTB depth, power of two >= 2; IDX_W = log2(BTB_ENTRIES)
//  CTR_BITS    2   saturating-counter width, >= 1; predict taken when MSB = 1
//  PERF_W      32  width of the branch and mispredict performance counters
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous active-low reset
//  if_valid_i       in   1      IF fetch valid
//  if_pc_i          in   XLEN   IF fetch PC
//  pred_taken_o     out  1      BTB hit with counter MSB = 1 (comb from IF inputs)
//  pred_target_o    out  XLEN   predicted target; 0 when pred_taken_o = 0
//  ex_valid_i       in   1      EX instruction valid (pipeline gates bubbles/flushes)
//  ex_pc_i          in   XLEN   EX instruction PC
//  ex_opcode_i      in   5      Inst[6:2]: 24 BRANCH, 27 JAL, 25 JALR, 13 LUI, 5 AUIPC
//  ex_funct3_i      in   3      Inst[14:12]
//  ex_br_eq_i       in   1      comparator rs1 == rs2
//  ex_br_lt_i       in   1      comparator rs1 < rs2 (signedness per br_un_o)
//  ex_target_i      in   XLEN   ALU-computed target (PC+imm or rs1+imm, bit0 cleared)
//  ex_pred_taken_i  in   1      prediction carried down the pipe with this instr
//  ex_pred_target_i in   XLEN   predicted target carried down the pipe
//  br_un_o          out  1      1 when BRANCH and funct3[1] = 1 (BLTU/BGEU)
//  a_sel_o          out  1      1 = ALU A operand is PC (BRANCH, JAL, LUI, AUIPC)
//  ex_taken_o       out  1      resolved taken
//  redirect_o       out  1      mispredict: flush IF/ID, load redirect_pc_o
//  redirect_pc_o    out  XLEN   taken ? ex_target_i : ex_pc_i + 4
//  perf_branches_o  out  PERF_W resolved BRANCH/JAL/JALR count
//  perf_mispred_o   out  PERF_W redirect count
// BEHAVIOUR
//  - Reset: all BTB valid bits, tags, targets, counters = 0; perf counters = 0;
//    comb outputs then follow inputs (pred_taken_o = 0, no hits).
//  - BTB index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; entry {valid,tag,target,ctr}.
//  - Lookup is combinational, zero latency; pred outputs 0 when if_valid_i = 0.
//  - Resolution (comb, only when ex_valid_i = 1; else ex_taken_o/redirect_o = 0):
//    JAL/JALR taken. BRANCH f3 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT;
//    010/011 never taken. Other opcodes not taken.
//  - a_sel_o/br_un_o decode from ex_opcode_i/funct3 regardless of ex_valid_i.
//  - redirect_o = taken != ex_pred_taken_i, or taken && target != ex_pred_target_i.
//    Non-control instr predicted taken (alias) -> redirect to PC+4.
//  - redirect_pc_o arithmetic modulo 2^XLEN (PC+4 wraps).
//  - Training on rising edge when ex_valid_i:
//    hit BRANCH: ctr +1 if taken / -1 if not, saturating at 0 and 2^CTR_BITS-1;
//      target <= ex_target_i when taken.
//    miss BRANCH taken: allocate (overwrite index), ctr = 2^(CTR_BITS-1) (weak taken).
//    miss BRANCH not taken: no change.
//    JAL/JALR hit or miss: write entry, ctr = all ones, target <= ex_target_i.
//    Non-control hit: clear valid bit. Non-control miss: no change.
//  - Same-cycle IF lookup and EX write to one index: IF sees old contents (no bypass).
//  - perf_branches_o +1 per valid BRANCH/JAL/JALR; perf_mispred_o +1 per redirect;
//    both saturate at all ones, never wrap.
//  - rst_n asserted mid-operation clears all state immediately; no partial update.
// TESTING
//  1 Reset, fetch any PC -> pred_taken_o=0, pred_target_o=0, perf counters 0.
//  2 BEQ @0x100 BrEq=1 pred 0, target 0x80 -> redirect_o=1, redirect_pc_o=0x80;
//    next fetch 0x100 -> pred_taken_o=1 (ctr 10), pred_target_o=0x80.
//  3 Same BEQ not taken twice -> ctr 01 then 00; first not-taken redirects to 0x104.
//  4 BGEU f3=111, BrLT=0 -> br_un_o=1, ex_taken_o=1; BLT BrLT=1 -> br_un_o=0, taken.
//  5 JALR @0x200 pred taken to 0x300, actual 0x340 -> redirect 0x340, entry updated.
//  6 ADDI predicted taken via alias -> redirect PC+4, entry invalidated; PC 0xFFFFFFFC
//    not-taken redirect -> 0x0; perf_mispred_o held at all ones stays saturated.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
// The IF side looks up a direct-mapped BTB with saturating counters to give a predicted next PC.
// The EX side resolves BRANCH/JAL/JALR, drives BrUn/ASel, flags mispredicts with a redirect PC,
// trains the BTB and keeps saturating performance counters.
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [4:0]        ex_opcode_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic              ex_br_eq_i,
    input  logic              ex_br_lt_i,
    input  logic [XLEN-1:0]   ex_target_i,
    input  logic              ex_pred_taken_i,
    input  logic [XLEN-1:0]   ex_pred_target_i,
    output logic              br_un_o,
    output logic              a_sel_o,
    output logic              ex_taken_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [PERF_W-1:0] perf_branches_o,
    output logic [PERF_W-1:0] perf_mispred_o
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic [4:0] {
        OP_AUIPC  = 5'd5,
        OP_LUI    = 5'd13,
        OP_BRANCH = 5'd24,
        OP_JALR   = 5'd25,
        OP_JAL    = 5'd27
    } opcode_e;

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
    logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             is_branch;
    logic             is_jump;
    logic             br_cond;
    logic             if_pc_unused;

    // The low PC bits only select bytes within an instruction word
    assign if_pc_unused = ^if_pc_i[1:0];

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign if_tag = if_pc_i[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[XLEN-1:IDX_W+2];

    // IF-side lookup: zero-latency and reads the stored contents, so a same-cycle EX write is not seen
    always_comb begin
        if_hit        = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
        pred_taken_o  = if_valid_i && if_hit && btb_ctr[if_idx][CTR_BITS-1];
        pred_target_o = pred_taken_o ? btb_target[if_idx] : '0;
    end

    // EX-side decode and branch resolution
    always_comb begin
        ex_hit    = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        is_branch = (ex_opcode_i == OP_BRANCH);
        is_jump   = (ex_opcode_i == OP_JAL) || (ex_opcode_i == OP_JALR);
        br_un_o   = is_branch && ex_funct3_i[1];
        a_sel_o   = is_branch || (ex_opcode_i == OP_JAL) ||
                    (ex_opcode_i == OP_LUI) || (ex_opcode_i == OP_AUIPC);
        br_cond   = 1'b0;
        unique case (ex_funct3_i)
            3'b000:         br_cond = ex_br_eq_i;
            3'b001:         br_cond = !ex_br_eq_i;
            3'b100, 3'b110: br_cond = ex_br_lt_i;
            3'b101, 3'b111: br_cond = !ex_br_lt_i;
            default:        br_cond = 1'b0;
        endcase
        ex_taken_o    = ex_valid_i && (is_jump || (is_branch && br_cond));
        redirect_o    = ex_valid_i &&
                        ((ex_taken_o != ex_pred_taken_i) ||
                         (ex_taken_o && (ex_target_i != ex_pred_target_i)));
        redirect_pc_o = ex_taken_o ? ex_target_i : ex_pc_i + XLEN'(4);
    end

    // BTB training from resolved EX instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= '0;
            end
        end else if (ex_valid_i) begin
            if (is_branch) begin
                if (ex_hit) begin
                    if (ex_taken_o) begin
                        btb_target[ex_idx] <= ex_target_i;
                        if (btb_ctr[ex_idx] != '1)
                            btb_ctr[ex_idx] <= btb_ctr[ex_idx] + CTR_BITS'(1);
                    end else if (btb_ctr[ex_idx] != '0) begin
                        btb_ctr[ex_idx] <= btb_ctr[ex_idx] - CTR_BITS'(1);
                    end
                end else if (ex_taken_o) begin
                    btb_valid[ex_idx]  <= 1'b1;
                    btb_tag[ex_idx]    <= ex_tag;
                    btb_target[ex_idx] <= ex_target_i;
                    btb_ctr[ex_idx]    <= CTR_WEAK;
                end
            end else if (is_jump) begin
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= ex_target_i;
                btb_ctr[ex_idx]    <= '1;
            end else if (ex_hit) begin
                btb_valid[ex_idx] <= 1'b0;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            if (ex_valid_i && (is_branch || is_jump) && (perf_branches_o != '1))
                perf_branches_o <= perf_branches_o + PERF_W'(1);
            if (redirect_o && (perf_mispred_o != '1))
                perf_mispred_o <= perf_mispred_o + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (narrow perf counters so saturation is reachable).
module tb_branch_predict_unit;

    localparam int unsigned PW = 4;

    logic          clk;
    logic          rst_n;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [4:0]    ex_opcode;
    logic [2:0]    ex_funct3;
    logic          ex_br_eq;
    logic          ex_br_lt;
    logic [31:0]   ex_target;
    logic          ex_pred_taken;
    logic [31:0]   ex_pred_target;
    logic          br_un;
    logic          a_sel;
    logic          ex_taken;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [PW-1:0] perf_branches;
    logic [PW-1:0] perf_mispred;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(
        .XLEN(32),
        .BTB_ENTRIES(16),
        .CTR_BITS(2),
        .PERF_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_valid_i(if_valid),
        .if_pc_i(if_pc),
        .pred_taken_o(pred_taken),
        .pred_target_o(pred_target),
        .ex_valid_i(ex_valid),
        .ex_pc_i(ex_pc),
        .ex_opcode_i(ex_opcode),
        .ex_funct3_i(ex_funct3),
        .ex_br_eq_i(ex_br_eq),
        .ex_br_lt_i(ex_br_lt),
        .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken),
        .ex_pred_target_i(ex_pred_target),
        .br_un_o(br_un),
        .a_sel_o(a_sel),
        .ex_taken_o(ex_taken),
        .redirect_o(redirect),
        .redirect_pc_o(redirect_pc),
        .perf_branches_o(perf_branches),
        .perf_mispred_o(perf_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [4:0] op,
                            input logic [2:0] f3, input logic eq, input logic lt,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_opcode      = op;
        ex_funct3      = f3;
        ex_br_eq       = eq;
        ex_br_lt       = lt;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch(1'b1, 32'h100);
        drive_ex(1'b0, 32'h0, 5'd4, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // 1: reset state
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h0);
        chk("rst_perf_br", {28'b0, perf_branches}, 32'd0);
        chk("rst_perf_mp", {28'b0, perf_mispred}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: BEQ taken, predicted not taken -> allocate weak taken
        drive_ex(1'b1, 32'h100, 5'd24, 3'b000, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("beq_taken", {31'b0, ex_taken}, 32'd1);
        chk("beq_redirect", {31'b0, redirect}, 32'd1);
        chk("beq_rpc", redirect_pc, 32'h80);
        chk("beq_asel", {31'b0, a_sel}, 32'd1);
        chk("beq_brun", {31'b0, br_un}, 32'd0);
        chk("same_cycle_no_bypass", {31'b0, pred_taken}, 32'd0);
        tick();
        drive_ex(1'b0, 32'h100, 5'd24, 3'b000, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("alloc_pred_target", pred_target, 32'h80);
        chk("perf_br_1", {28'b0, perf_branches}, 32'd1);
        chk("perf_mp_1", {28'b0, perf_mispred}, 32'd1);

        // 3: not taken twice -> ctr 01 then 00
        drive_ex(1'b1, 32'h100, 5'd24, 3'b000, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("nt1_taken", {31'b0, ex_taken}, 32'd0);
        chk("nt1_redirect", {31'b0, redirect}, 32'd1);
        chk("nt1_rpc", redirect_pc, 32'h104);
        tick();
        chk("ctr01_pred", {31'b0, pred_taken}, 32'd0);
        chk("ctr01_target", pred_target, 32'h0);
        drive_ex(1'b1, 32'h100, 5'd24, 3'b000, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("nt2_redirect", {31'b0, redirect}, 32'd0);
        tick();
        // ctr 00 -> taken gives 01 (still predicts not taken), then 10
        drive_ex(1'b1, 32'h100, 5'd24, 3'b000, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        tick();
        chk("ctr01_again_pred", {31'b0, pred_taken}, 32'd0);
        tick();
        drive_ex(1'b0, 32'h100, 5'd24, 3'b000, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("ctr10_pred", {31'b0, pred_taken}, 32'd1);
        chk("perf_br_5", {28'b0, perf_branches}, 32'd5);
        chk("perf_mp_4", {28'b0, perf_mispred}, 32'd4);

        // 4: comparator decode, never clocked with ex_valid high
        drive_ex(1'b1, 32'h400, 5'd24, 3'b111, 1'b0, 1'b0, 32'h480, 1'b0, 32'h0);
        chk("bgeu_brun", {31'b0, br_un}, 32'd1);
        chk("bgeu_taken", {31'b0, ex_taken}, 32'd1);
        drive_ex(1'b1, 32'h400, 5'd24, 3'b100, 1'b0, 1'b1, 32'h480, 1'b0, 32'h0);
        chk("blt_brun", {31'b0, br_un}, 32'd0);
        chk("blt_taken", {31'b0, ex_taken}, 32'd1);
        drive_ex(1'b1, 32'h400, 5'd24, 3'b001, 1'b1, 1'b0, 32'h480, 1'b0, 32'h0);
        chk("bne_eq_taken", {31'b0, ex_taken}, 32'd0);
        drive_ex(1'b1, 32'h400, 5'd24, 3'b010, 1'b1, 1'b1, 32'h480, 1'b0, 32'h0);
        chk("f3_010_taken", {31'b0, ex_taken}, 32'd0);
        drive_ex(1'b0, 32'h400, 5'd24, 3'b110, 1'b0, 1'b1, 32'h480, 1'b0, 32'h0);
        chk("invalid_taken", {31'b0, ex_taken}, 32'd0);
        chk("invalid_brun", {31'b0, br_un}, 32'd1);
        chk("invalid_asel", {31'b0, a_sel}, 32'd1);

        // 5: JALR wrong target, replaces the BEQ entry at index 0
        drive_ex(1'b1, 32'h200, 5'd25, 3'b000, 1'b0, 1'b0, 32'h340, 1'b1, 32'h300);
        chk("jalr_redirect", {31'b0, redirect}, 32'd1);
        chk("jalr_rpc", redirect_pc, 32'h340);
        chk("jalr_asel", {31'b0, a_sel}, 32'd0);
        tick();
        drive_ex(1'b0, 32'h200, 5'd25, 3'b000, 1'b0, 1'b0, 32'h340, 1'b1, 32'h300);
        fetch(1'b1, 32'h200);
        chk("jalr_pred", {31'b0, pred_taken}, 32'd1);
        chk("jalr_target", pred_target, 32'h340);
        fetch(1'b0, 32'h200);
        chk("if_invalid_pred", {31'b0, pred_taken}, 32'd0);
        fetch(1'b1, 32'h100);
        chk("evicted_pred", {31'b0, pred_taken}, 32'd0);
        drive_ex(1'b1, 32'h200, 5'd27, 3'b000, 1'b0, 1'b0, 32'h340, 1'b1, 32'h340);
        chk("jal_ok_redirect", {31'b0, redirect}, 32'd0);
        tick();

        // 6: ADDI aliasing onto the JAL entry -> redirect PC+4, invalidate
        drive_ex(1'b1, 32'h200, 5'd4, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h340);
        chk("alias_redirect", {31'b0, redirect}, 32'd1);
        chk("alias_rpc", redirect_pc, 32'h204);
        tick();
        fetch(1'b1, 32'h200);
        chk("alias_invalidated", {31'b0, pred_taken}, 32'd0);
        drive_ex(1'b1, 32'hFFFF_FFFC, 5'd4, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8);
        chk("wrap_rpc", redirect_pc, 32'h0);
        tick();
        chk("perf_br_7", {28'b0, perf_branches}, 32'd7);
        chk("perf_mp_7", {28'b0, perf_mispred}, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        chk("mp_saturated", {28'b0, perf_mispred}, 32'hF);
        drive_ex(1'b1, 32'h500, 5'd24, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("br_saturated", {28'b0, perf_branches}, 32'hF);
        chk("mp_held", {28'b0, perf_mispred}, 32'hF);

        // Asynchronous reset mid-operation
        drive_ex(1'b1, 32'h200, 5'd27, 3'b000, 1'b0, 1'b0, 32'h600, 1'b0, 32'h0);
        tick();
        fetch(1'b1, 32'h200);
        chk("pre_rst_pred", {31'b0, pred_taken}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pred", {31'b0, pred_taken}, 32'd0);
        chk("async_rst_perf_br", {28'b0, perf_branches}, 32'd0);
        chk("async_rst_perf_mp", {28'b0, perf_mispred}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
